// File: rtl/div_issue_ctrl_if.sv
// Divider-side bus of the EXE-stage divide sequencer: launch/clear
// controls and latched operands go out, the done pulse and the
// {quotient, remainder} result come back.
interface div_issue_ctrl_if;
  logic        div_start;
  logic        div_sclr;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done;
  logic [63:0] div_result;

  // Sequencer side: drives the divider, consumes its result.
  modport master (
    output div_start, div_sclr, div_signed, div_dividend, div_divisor,
    input  div_done, div_result
  );

  // Divider side.
  modport slave (
    input  div_start, div_sclr, div_signed, div_dividend, div_divisor,
    output div_done, div_result
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Sequencing controller for the multi-cycle radix-2 divider in EXE.
// Latches DIV/DIVU operands, launches the divider with a one-cycle pulse,
// stalls the pipeline until completion and writes HI/LO once. Divide by
// zero bypasses the divider; flush and a watchdog both abort cleanly.
module div_issue_ctrl #(
  parameter int DIV_LATENCY = 32,
  parameter int WATCHDOG    = DIV_LATENCY + 4
) (
  input  logic                   clk,
  input  logic                   sclr,
  input  logic                   req_valid,
  input  logic                   req_signed,
  input  logic [31:0]            req_dividend,
  input  logic [31:0]            req_divisor,
  input  logic                   flush,
  output logic                   stall_o,
  div_issue_ctrl_if.master       dbus,
  output logic                   hilo_we,
  output logic [31:0]            hi_o,
  output logic [31:0]            lo_o,
  output logic                   err_o
);

  // Wide enough to hold WATCHDOG itself so the counter can saturate.
  localparam int CW = $clog2(WATCHDOG + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          signed_reg;
  logic [31:0]   dividend_reg, divisor_reg;
  logic [31:0]   hi_reg, lo_reg;

  logic latch_ops, load_zero, load_result;
  logic start_c, we_c, abort_c, flush_sclr_c;

  // Next-state and per-cycle strobes; flush overrides everything last.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    latch_ops    = 1'b0;
    load_zero    = 1'b0;
    load_result  = 1'b0;
    start_c      = 1'b0;
    we_c         = 1'b0;
    abort_c      = 1'b0;
    flush_sclr_c = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid && !flush) begin
          latch_ops = 1'b1;
          if (req_divisor != 32'd0) begin
            state_next = START;
          end else begin
            // x/0 never touches the divider: result is fixed.
            load_zero  = 1'b1;
            state_next = DONE;
          end
        end
      end
      START: begin
        start_c    = 1'b1;
        cnt_next   = '0;
        state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg != CW'(WATCHDOG)) begin
          cnt_next = cnt_reg + 1'b1;
        end
        // A done arriving on the last allowed cycle still counts.
        if (dbus.div_done) begin
          load_result = 1'b1;
          state_next  = DONE;
        end else if (cnt_reg == CW'(WATCHDOG - 1)) begin
          abort_c    = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        we_c       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush) begin
      state_next   = IDLE;
      start_c      = 1'b0;
      we_c         = 1'b0;
      load_result  = 1'b0;
      abort_c      = 1'b0;
      flush_sclr_c = (state_reg == START) || (state_reg == BUSY);
    end
  end

  // FSM state and watchdog counter.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Operand latches (only on acceptance) and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (sclr) begin
      signed_reg   <= 1'b0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      if (latch_ops) begin
        signed_reg   <= req_signed;
        dividend_reg <= req_dividend;
        divisor_reg  <= req_divisor;
      end
      if (load_zero) begin
        hi_reg <= req_dividend;
        lo_reg <= 32'hFFFF_FFFF;
      end else if (load_result) begin
        hi_reg <= dbus.div_result[31:0];
        lo_reg <= dbus.div_result[63:32];
      end
    end
  end

  // Stall is combinational so the instruction freezes in the cycle it appears.
  assign stall_o           = req_valid & ~flush & (state_reg != DONE);
  assign dbus.div_start    = start_c & ~sclr;
  assign dbus.div_sclr     = sclr | flush_sclr_c | abort_c;
  assign dbus.div_signed   = signed_reg;
  assign dbus.div_dividend = dividend_reg;
  assign dbus.div_divisor  = divisor_reg;
  assign hilo_we           = we_c & ~sclr;
  assign err_o             = abort_c & ~sclr;
  assign hi_o              = hi_reg;
  assign lo_o              = lo_reg;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: fixed vector table, randomized divides against
// an arithmetic reference, and hand-written flush/watchdog/reset sequences.
module tb_div_issue_ctrl;
  localparam int DIV_LATENCY = 32;
  localparam int WATCHDOG    = DIV_LATENCY + 4;

  logic        clk = 1'b0;
  logic        sclr;
  logic        req_valid, req_signed, flush;
  logic [31:0] req_dividend, req_divisor;
  logic        stall_o, hilo_we, err_o;
  logic [31:0] hi_o, lo_o;

  div_issue_ctrl_if dbus ();

  div_issue_ctrl #(.DIV_LATENCY(DIV_LATENCY), .WATCHDOG(WATCHDOG)) dut (
    .clk(clk), .sclr(sclr),
    .req_valid(req_valid), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .flush(flush), .stall_o(stall_o), .dbus(dbus),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: {hi, lo} = {remainder, quotient}; x/0 gives {x, all ones}.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider stand-in: answers DIV_LATENCY cycles after a start pulse.
  logic        m_pending = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_result = '0;
  logic        m_hang = 1'b0;
  logic        inj_done = 1'b0;
  logic [63:0] m_tmp;

  assign m_tmp           = ref_div(dbus.div_signed, dbus.div_dividend, dbus.div_divisor);
  assign dbus.div_done   = (m_pending && m_cnt == 0 && !m_hang) || inj_done;
  assign dbus.div_result = m_result;

  // Model state advances on the clock; a divider clear drops any pending op.
  always @(posedge clk) begin
    if (dbus.div_sclr) begin
      m_pending <= 1'b0;
    end else if (dbus.div_start) begin
      m_pending <= 1'b1;
      m_cnt     <= DIV_LATENCY - 1;
      m_result  <= {m_tmp[31:0], m_tmp[63:32]};
    end else if (m_pending) begin
      if (m_cnt == 0) m_pending <= 1'b0;
      else            m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One request held until HI/LO is written; timing expectations from the rules.
  task automatic run_txn(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int stall_cnt, start_cyc, we_cyc, estall, estart, ewe;
    logic sig_at;
    logic [31:0] ghi, glo;
    stall_cnt = 0; start_cyc = -1; we_cyc = -1; sig_at = 1'b0; ghi = '0; glo = '0;
    if (b != 32'd0) begin
      estall = DIV_LATENCY + 2; estart = 1; ewe = DIV_LATENCY + 2;
    end else begin
      estall = 1; estart = -1; ewe = 1;
    end
    req_valid = 1'b1; req_signed = sgn; req_dividend = a; req_divisor = b;
    for (int c = 0; c < DIV_LATENCY + 10 && we_cyc < 0; c++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (dbus.div_start && start_cyc < 0) begin
        start_cyc = c;
        sig_at = dbus.div_signed;
      end
      if (hilo_we) begin
        we_cyc = c; ghi = hi_o; glo = lo_o;
      end
      next_cycle();
    end
    req_valid = 1'b0; req_dividend = $urandom; req_divisor = $urandom;
    check({tag, "_stall"}, 64'(stall_cnt), 64'(estall));
    check({tag, "_start"}, 64'(start_cyc), 64'(estart));
    check({tag, "_we"},    64'(we_cyc),    64'(ewe));
    check({tag, "_hi"},    64'(ghi),       64'(ehi));
    check({tag, "_lo"},    64'(glo),       64'(elo));
    if (estart >= 0) check({tag, "_signed"}, 64'(sig_at), 64'(sgn));
    $display("txn %s sgn=%0d %h/%h -> hi=%h lo=%h stall=%0d", tag, sgn, a, b, ghi, glo, stall_cnt);
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    logic [31:0] h0, l0, a, b;
    logic [63:0] exp;
    logic sgn, sc_at;
    int we_n, err_n, err_cyc, st_n;

    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
    tbl[2] = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF};
    tbl[3] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD};
    tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'd16,         32'd15,         32'h0FFF_FFFF};
    tbl[5] = '{1'b1, 32'h1234_5678,  32'd0,          32'h1234_5678,  32'hFFFF_FFFF};

    sclr = 1'b1; req_valid = 1'b0; req_signed = 1'b0; flush = 1'b0;
    req_dividend = '0; req_divisor = '0;
    repeat (3) next_cycle();

    // Reset state, sampled while sclr is still asserted.
    @(negedge clk);
    check("rst_sclr",   64'(dbus.div_sclr),     64'd1);
    check("rst_start",  64'(dbus.div_start),    64'd0);
    check("rst_we",     64'(hilo_we),           64'd0);
    check("rst_err",    64'(err_o),             64'd0);
    check("rst_hilo",   {hi_o, lo_o},           64'd0);
    check("rst_ops",    {dbus.div_dividend, dbus.div_divisor}, 64'd0);
    check("rst_signed", 64'(dbus.div_signed),   64'd0);
    next_cycle();
    sclr = 1'b0;

    // Table, back to back: each request lands in the IDLE cycle after DONE.
    for (int i = 0; i < 6; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo);

    // Randomized divides against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      int r;
      sgn = 1'($urandom);
      a = $urandom;
      r = $urandom_range(0, 7);
      b = (r == 0) ? 32'd0 : (r < 4) ? 32'($urandom_range(1, 20)) : $urandom;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      exp = ref_div(sgn, a, b);
      run_txn($sformatf("rnd%0d", i), sgn, a, b, exp[63:32], exp[31:0]);
    end

    // Flush in BUSY cycle 10; a late div_done must not write HI/LO.
    h0 = hi_o; l0 = lo_o; we_n = 0;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd1000; req_divisor = 32'd3;
    repeat (12) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_sclr",  64'(dbus.div_sclr), 64'd1);
    check("flush_stall", 64'(stall_o),       64'd0);
    next_cycle();
    flush = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      inj_done = (c == 10);
      @(negedge clk);
      if (hilo_we) we_n++;
      next_cycle();
    end
    inj_done = 1'b0;
    check("flush_no_we", 64'(we_n), 64'd0);
    check("flush_hilo",  {hi_o, lo_o}, {h0, l0});
    $display("txn flush_busy we=%0d", we_n);
    run_txn("post_flush", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333);

    // Hung divider: watchdog abort, no write.
    h0 = hi_o; l0 = lo_o; we_n = 0; err_n = 0; err_cyc = -1; sc_at = 1'b0;
    m_hang = 1'b1;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd50; req_divisor = 32'd5;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (err_o) begin
        err_n++;
        if (err_cyc < 0) begin err_cyc = c; sc_at = dbus.div_sclr; end
      end
      if (hilo_we) we_n++;
      next_cycle();
      if (err_cyc == c) req_valid = 1'b0;
    end
    req_valid = 1'b0; m_hang = 1'b0;
    check("wdog_cycle", 64'(err_cyc), 64'(WATCHDOG + 1));
    check("wdog_sclr",  64'(sc_at),   64'd1);
    check("wdog_pulse", 64'(err_n),   64'd1);
    check("wdog_no_we", 64'(we_n),    64'd0);
    check("wdog_hilo",  {hi_o, lo_o}, {h0, l0});
    $display("txn watchdog err_cycle=%0d", err_cyc);

    // Flush and div_done in the same BUSY cycle: flush wins.
    run_txn("pre_fd", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7);
    h0 = hi_o; l0 = lo_o; we_n = 0;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd200; req_divisor = 32'd9;
    repeat (1 + DIV_LATENCY) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("fd_done_seen", 64'(dbus.div_done), 64'd1);
    check("fd_sclr",      64'(dbus.div_sclr), 64'd1);
    check("fd_we",        64'(hilo_we),       64'd0);
    next_cycle();
    flush = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (hilo_we) we_n++;
      next_cycle();
    end
    check("fd_no_we", 64'(we_n), 64'd0);
    check("fd_hilo",  {hi_o, lo_o}, {h0, l0});
    $display("txn flush_with_done we=%0d", we_n);

    // sclr mid-BUSY discards the divide and clears everything.
    run_txn("pre_rst", tbl[0].sgn, tbl[0].a, tbl[0].b, tbl[0].ehi, tbl[0].elo);
    we_n = 0; st_n = 0;
    req_valid = 1'b1; req_signed = 1'b1; req_dividend = 32'd999; req_divisor = 32'd4;
    repeat (15) next_cycle();
    sclr = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_sclr",  64'(dbus.div_sclr),  64'd1);
    check("mid_rst_start", 64'(dbus.div_start), 64'd0);
    check("mid_rst_we",    64'(hilo_we),        64'd0);
    next_cycle();
    @(negedge clk);
    check("mid_rst_hilo",   {hi_o, lo_o}, 64'd0);
    check("mid_rst_ops",    {dbus.div_dividend, dbus.div_divisor}, 64'd0);
    check("mid_rst_signed", 64'(dbus.div_signed), 64'd0);
    next_cycle();
    sclr = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_we) we_n++;
      if (dbus.div_start) st_n++;
      next_cycle();
    end
    check("mid_rst_no_we",    64'(we_n), 64'd0);
    check("mid_rst_no_start", 64'(st_n), 64'd0);
    $display("txn sclr_mid_busy we=%0d", we_n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
